// File: rtl/magic_square_gen.sv
// rtl/magic_square_gen.sv - streams the Lo Shu magic squares over a valid/ready grid interface
module magic_square_gen #(
    parameter bit MIRROR_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] num5,
    output logic [3:0] num6,
    output logic [3:0] num7,
    output logic [3:0] num8,
    output logic [3:0] num9,
    output logic [2:0] index,
    output logic       done
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [2:0] LAST = MIRROR_EN ? 3'd7 : 3'd3;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  index_nx;
    logic        done_nx;
    logic [35:0] grid;

    // Each hex digit is one cell, num1 in the top nibble.
    function automatic logic [35:0] grid_of(input logic [2:0] i);
        case (i)
            3'd0:    grid_of = 36'h276951438;
            3'd1:    grid_of = 36'h492357816;
            3'd2:    grid_of = 36'h834159672;
            3'd3:    grid_of = 36'h618753294;
            3'd4:    grid_of = 36'h672159834;
            3'd5:    grid_of = 36'h294753618;
            3'd6:    grid_of = 36'h438951276;
            default: grid_of = 36'h816357492;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= 3'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            index <= index_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        index_nx = index;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = EMIT;
                    index_nx = 3'd0;
                end
            end
            EMIT: begin
                if (ready) begin
                    if (index == LAST) begin
                        state_nx = IDLE;
                        index_nx = 3'd0;
                        done_nx  = 1'b1;
                    end else begin
                        index_nx = index + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode straight from reset-cleared registers, so reset blanks them at once.
    assign valid = (state == EMIT);
    assign grid  = valid ? grid_of(index) : 36'd0;
    assign {num1, num2, num3, num4, num5, num6, num7, num8, num9} = grid;

endmodule
